tempo_scheduler: RTL and testbench

Game-tempo controller for the tile-scroll datapath. Derives a one-cycle `tick` enable from `CLOCK_50` whose interval is a whole number of milliseconds. The interval shortens as the game level rises, down to a floor. Supports start/stop/pause so the tile engine, note player and display logic all advance from one shared, sequenced tempo source.

---
 rtl/tempo_pkg.sv | 35 +++
 rtl/tempo_scheduler_prescaler.sv | 32 +++
 rtl/tempo_scheduler.sv | 121 ++++++++++++
 tb/tb_tempo_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared types and constants for the game-tempo controller.
// Holds the FSM state encoding, default timing parameters and the period helper.
package tempo_pkg;

   localparam int unsigned LEVEL_W = 4;
   localparam int unsigned MS_W    = 20;

   localparam int unsigned DEF_CLK_PER_MS = 50000;
   localparam int unsigned DEF_INIT_MS    = 500;
   localparam int unsigned DEF_STEP_MS    = 25;
   localparam int unsigned DEF_MIN_MS     = 100;
   localparam int unsigned DEF_MAX_LEVEL  = 15;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED
   } tempo_state_t;

   // Interval for a level, floored at min_ms; compares before subtracting so it never wraps.
   function automatic logic [MS_W-1:0] calc_period(
      input logic [LEVEL_W-1:0] lvl,
      input logic [MS_W-1:0]    init_ms,
      input logic [MS_W-1:0]    step_ms,
      input logic [MS_W-1:0]    min_ms
   );
      logic [MS_W-1:0] dec;
      dec = MS_W'(lvl) * step_ms;
      if ((init_ms >= min_ms) && ((init_ms - min_ms) >= dec))
         calc_period = init_ms - dec;
      else
         calc_period = min_ms;
   endfunction

endpackage

// File: rtl/tempo_scheduler_prescaler.sv
// Modulo-CLK_PER_MS prescaler producing a one-cycle ms_tick at its terminal count.
// A clr together with en restarts the count with the current cycle already counted.
module ms_prescaler
   import tempo_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = DEF_CLK_PER_MS
) (
   input  logic CLOCK_50,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic ms_tick
);

   localparam int unsigned CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_MS - 1);
   localparam logic [CNT_W-1:0] FIRST = (CLK_PER_MS > 1) ? CNT_W'(1) : '0;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= en ? FIRST : '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign ms_tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/tempo_scheduler.sv
// Shared tempo source: start/stop/pause FSM, ms counter, level ramp and tick generation.
// The start cycle counts as the first prescaler cycle so the first tick lands period*CLK_PER_MS later.
module tempo_scheduler
   import tempo_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = DEF_CLK_PER_MS,
   parameter int unsigned INIT_MS    = DEF_INIT_MS,
   parameter int unsigned STEP_MS    = DEF_STEP_MS,
   parameter int unsigned MIN_MS     = DEF_MIN_MS,
   parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL
) (
   input  logic               CLOCK_50,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               level_up,
   output logic               tick,
   output logic               running,
   output logic [LEVEL_W-1:0] level,
   output logic [MS_W-1:0]    period_ms
);

   localparam logic [MS_W-1:0]    INIT_P = MS_W'(INIT_MS);
   localparam logic [MS_W-1:0]    STEP_P = MS_W'(STEP_MS);
   localparam logic [MS_W-1:0]    MIN_P  = MS_W'(MIN_MS);
   localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(MAX_LEVEL);

   tempo_state_t state, state_nxt;

   logic [MS_W-1:0]    ms_cnt;
   logic               pending;
   logic               active;
   logic               start_go;
   logic               pre_clr;
   logic               pre_en;
   logic               ms_tick;
   logic               fire;
   logic               lu_ok;
   logic [LEVEL_W-1:0] lvl_next;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !stop) state_nxt = RUN;
         RUN:     if (stop) state_nxt = IDLE;
                  else if (pause) state_nxt = PAUSED;
         PAUSED:  if (stop) state_nxt = IDLE;
                  else if (!pause) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Counting runs whenever pause is low outside IDLE, so the resume cycle itself counts.
   assign active   = (state != IDLE);
   assign start_go = (state == IDLE) && start && !stop;
   assign pre_clr  = (state == IDLE) || stop;
   assign pre_en   = start_go || (active && !pause && !stop);

   ms_prescaler #(
      .CLK_PER_MS(CLK_PER_MS)
   ) u_prescaler (
      .CLOCK_50(CLOCK_50),
      .rst_n   (rst_n),
      .clr     (pre_clr),
      .en      (pre_en),
      .ms_tick (ms_tick)
   );

   assign fire     = ms_tick && (ms_cnt == (period_ms - MS_W'(1)));
   assign lu_ok    = level_up && active;
   assign lvl_next = (level == MAX_L) ? level : level + 1'b1;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         ms_cnt <= '0;
      else if (pre_clr)
         ms_cnt <= '0;
      else if (ms_tick)
         ms_cnt <= fire ? '0 : ms_cnt + 1'b1;
   end

   // A request arriving on the firing cycle survives the clear and waits for the next tick.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         level     <= '0;
         period_ms <= INIT_P;
         pending   <= 1'b0;
      end else if (start_go) begin
         level     <= '0;
         period_ms <= INIT_P;
         pending   <= 1'b0;
      end else if (fire) begin
         if (pending) begin
            level     <= lvl_next;
            period_ms <= calc_period(lvl_next, INIT_P, STEP_P, MIN_P);
         end
         pending <= lu_ok;
      end else if (lu_ok) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         tick    <= 1'b0;
         running <= 1'b0;
      end else begin
         tick    <= fire;
         running <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_tempo_scheduler.sv
// Self-checking bench for tempo_scheduler with a tick scoreboard keyed on cycle number.
module tb_tempo_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        pause;
   logic        level_up;
   logic        tick;
   logic        running;
   logic [3:0]  level;
   logic [19:0] period_ms;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      int lvl;
      int per;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tempo_scheduler #(
      .CLK_PER_MS(4),
      .INIT_MS   (5),
      .STEP_MS   (1),
      .MIN_MS    (2),
      .MAX_LEVEL (15)
   ) dut (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .level_up (level_up),
      .tick     (tick),
      .running  (running),
      .level    (level),
      .period_ms(period_ms)
   );

   function automatic exp_t mk(input int c, input int l, input int p);
      exp_t e;
      e.cyc = c;
      e.lvl = l;
      e.per = p;
      return e;
   endfunction

   // Scoreboard consumer: samples the current cycle at negedge, then moves to the next cycle.
   task automatic advance();
      exp_t e;
      @(negedge clk);
      if (tick === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL tick_unexpected: tick at cycle %0d, required no tick", cyc);
         end else begin
            e = sb.pop_front();
            if (cyc !== e.cyc || int'(level) !== e.lvl || int'(period_ms) !== e.per) begin
               errors++;
               $display("FAIL tick_match: got cycle %0d level %0d period %0d, required cycle %0d level %0d period %0d",
                        cyc, level, period_ms, e.cyc, e.lvl, e.per);
            end
         end
      end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
         checks++;
         errors++;
         e = sb.pop_front();
         $display("FAIL tick_missing: no tick at cycle %0d, required tick (level %0d period %0d)", cyc, e.lvl, e.per);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; level_up = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tick !== 1'b0 || running !== 1'b0 || level !== 4'd0 || period_ms !== 20'd5) begin
         errors++;
         $display("FAIL reset_values: tick %b running %b level %0d period %0d, required 0 0 0 5",
                  tick, running, level, period_ms);
      end
      rst_n = 1'b1;
      repeat (4) advance();
      checks++;
      if (running !== 1'b0 || level !== 4'd0 || period_ms !== 20'd5) begin
         errors++;
         $display("FAIL idle_hold: running %b level %0d period %0d, required 0 0 5", running, level, period_ms);
      end
   endtask

   task automatic test_basic();
      int base;
      base = cyc;
      start = 1'b1;
      sb.push_back(mk(base + 20, 0, 5));
      sb.push_back(mk(base + 40, 0, 5));
      sb.push_back(mk(base + 60, 0, 5));
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL running_early: running %b, required 0", running);
      end
      advance();
      start = 1'b0;
      checks++;
      if (running !== 1'b1 || period_ms !== 20'd5) begin
         errors++;
         $display("FAIL running_rise: running %b period %0d, required 1 5", running, period_ms);
      end
      for (int r = 2; r < 62; r++) advance();
      stop = 1'b1;
      advance();
      stop = 1'b0;
      advance();
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL running_fall: running %b, required 0", running);
      end
   endtask

   task automatic test_level_ramp();
      int base;
      base = cyc;
      start = 1'b1;
      sb.push_back(mk(base + 20, 0, 5));
      sb.push_back(mk(base + 40, 1, 4));
      sb.push_back(mk(base + 56, 1, 4));
      sb.push_back(mk(base + 72, 1, 4));
      advance();
      start = 1'b0;
      for (int r = 1; r < 74; r++) begin
         level_up = (r == 25);
         advance();
      end
      level_up = 1'b0;
      stop = 1'b1;
      advance();
      stop = 1'b0;
   endtask

   task automatic test_floor();
      int base;
      int t;
      int lvl;
      int per;
      int pulses[$];
      base = cyc;
      t = 0; lvl = 0; per = 5;
      for (int k = 0; k < 20; k++) begin
         pulses.push_back(t + 2);
         t = t + per * 4;
         lvl = (lvl + 1 > 15) ? 15 : lvl + 1;
         per = (5 - lvl < 2) ? 2 : 5 - lvl;
         sb.push_back(mk(base + t, lvl, per));
      end
      start = 1'b1;
      advance();
      start = 1'b0;
      for (int r = 1; r <= t + 1; r++) begin
         level_up = 1'b0;
         if (pulses.size() > 0 && r == pulses[0]) begin
            level_up = 1'b1;
            void'(pulses.pop_front());
         end
         advance();
      end
      level_up = 1'b0;
      checks++;
      if (level !== 4'd15 || period_ms !== 20'd2) begin
         errors++;
         $display("FAIL floor_sat: level %0d period %0d, required 15 2", level, period_ms);
      end
      stop = 1'b1;
      advance();
      stop = 1'b0;
   endtask

   task automatic test_pause();
      int base;
      base = cyc;
      start = 1'b1;
      sb.push_back(mk(base + 40, 1, 4));
      sb.push_back(mk(base + 56, 1, 4));
      advance();
      start = 1'b0;
      for (int r = 1; r < 58; r++) begin
         pause    = (r >= 10 && r <= 29);
         level_up = (r == 15);
         if (r == 20) begin
            checks++;
            if (running !== 1'b1) begin
               errors++;
               $display("FAIL running_paused: running %b, required 1", running);
            end
         end
         advance();
      end
      pause = 1'b0;
      level_up = 1'b0;
      stop = 1'b1;
      advance();
      stop = 1'b0;
   endtask

   task automatic test_stop_restart();
      int base;
      checks++;
      if (level !== 4'd1 || period_ms !== 20'd4) begin
         errors++;
         $display("FAIL stop_keeps: level %0d period %0d, required 1 4", level, period_ms);
      end
      base = cyc;
      start = 1'b1;
      advance();
      start = 1'b0;
      checks++;
      if (level !== 4'd0 || period_ms !== 20'd5) begin
         errors++;
         $display("FAIL start_clears: level %0d period %0d, required 0 5", level, period_ms);
      end
      for (int r = 1; r < 30; r++) begin
         start = (r == 15);
         stop  = (r == 15);
         if (r == 16) begin
            checks++;
            if (running !== 1'b0) begin
               errors++;
               $display("FAIL stop_wins: running %b at cycle 16, required 0", running);
            end
         end
         advance();
      end
      stop = 1'b0;
      start = 1'b1;
      sb.push_back(mk(base + 50, 0, 5));
      advance();
      start = 1'b0;
      for (int r = 31; r < 52; r++) advance();
      stop = 1'b1;
      advance();
      stop = 1'b0;
   endtask

   task automatic test_async_reset();
      int base;
      base = cyc;
      start = 1'b1;
      sb.push_back(mk(base + 20, 1, 4));
      sb.push_back(mk(base + 36, 2, 3));
      advance();
      start = 1'b0;
      for (int r = 1; r < 41; r++) begin
         level_up = (r == 2 || r == 25);
         advance();
      end
      level_up = 1'b0;
      checks++;
      if (level !== 4'd2 || period_ms !== 20'd3 || running !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: level %0d period %0d running %b, required 2 3 1", level, period_ms, running);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (tick !== 1'b0 || running !== 1'b0 || level !== 4'd0 || period_ms !== 20'd5) begin
         errors++;
         $display("FAIL async_reset: tick %b running %b level %0d period %0d, required 0 0 0 5",
                  tick, running, level, period_ms);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) advance();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_level_ramp();
      test_floor();
      test_pause();
      test_stop_restart();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected ticks never seen, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
